// File: rtl/d2l_link_arbiter.sv
// d2l_link_arbiter: round-robin arbiter and transaction sequencer sharing one
// D2L serial link between NUM_REQ requesters.
//   clk, rst        : clock, asynchronous active-high reset
//   req, req_data   : per-requester request level and 64-bit payload slices
//   gnt             : one-hot grant, LAUNCH through RESP
//   rsp_valid       : one-cycle response pulse to the granted requester
//   rsp_data        : response word (0 on timeout)
//   rsp_timeout     : transaction was aborted by the WAIT timeout
//   busy            : not in IDLE
//   link_out_en     : one-cycle start pulse to the link
//   link_data_in    : payload to the link, held until the next grant
//   link_done       : link completion, asynchronous to clk
//   link_data_out   : link receive word, stable once link_done rises
module d2l_link_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*64-1:0]   req_data,
  output logic [NUM_REQ-1:0]      gnt,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [63:0]             rsp_data,
  output logic                    rsp_timeout,
  output logic                    busy,
  output logic                    link_out_en,
  output logic [63:0]             link_data_in,
  input  logic                    link_done,
  input  logic [63:0]             link_data_out
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] last_q, last_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [63:0]   data_in_q, data_in_d;
  logic [63:0]   rsp_data_q, rsp_data_d;
  logic          to_q, to_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          d1_q, d2_q, d3_q;

  logic          done_evt;
  logic          found;
  logic [IW-1:0] win;
  int unsigned   cand;

  assign done_evt = d2_q & ~d3_q;

  // Rotating priority: scan last+1, last+2, ... wrapping, first hit wins.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    cand  = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (int'(last_q) + i) % NUM_REQ;
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = IW'(cand);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    idx_d      = idx_q;
    data_in_d  = data_in_q;
    rsp_data_d = rsp_data_q;
    to_d       = to_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d   = S_LAUNCH;
          idx_d     = win;
          last_d    = win;
          data_in_d = req_data[int'(win)*64 +: 64];
          to_d      = 1'b0;
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        to_d    = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Completion is checked first so it wins over a coincident timeout.
        if (done_evt) begin
          rsp_data_d = link_data_out;
          to_d       = 1'b0;
          state_d    = S_RESP;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          rsp_data_d = '0;
          to_d       = 1'b1;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      last_q     <= LAST_RST;
      idx_q      <= '0;
      data_in_q  <= '0;
      rsp_data_q <= '0;
      to_q       <= 1'b0;
      cnt_q      <= '0;
      d1_q       <= 1'b0;
      d2_q       <= 1'b0;
      d3_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      idx_q      <= idx_d;
      data_in_q  <= data_in_d;
      rsp_data_q <= rsp_data_d;
      to_q       <= to_d;
      cnt_q      <= cnt_d;
      d1_q       <= link_done;
      d2_q       <= d1_q;
      d3_q       <= d2_q;
    end
  end

  always_comb begin
    gnt       = '0;
    rsp_valid = '0;
    if (state_q != S_IDLE) begin
      gnt[idx_q] = 1'b1;
    end
    if (state_q == S_RESP) begin
      rsp_valid[idx_q] = 1'b1;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign link_out_en  = (state_q == S_LAUNCH);
  assign link_data_in = data_in_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_timeout  = (state_q == S_RESP) && to_q;

endmodule

// File: tb/tb_d2l_link_arbiter.sv
module tb_d2l_link_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*64-1:0] req_data;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rsp_valid;
  logic [63:0]     rsp_data;
  logic            rsp_timeout;
  logic            busy;
  logic            link_out_en;
  logic [63:0]     link_data_in;
  logic            link_done;
  logic [63:0]     link_data_out;

  int total = 0;
  int bad   = 0;
  int last_m;

  always #5 clk = ~clk;

  d2l_link_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .busy(busy), .link_out_en(link_out_en), .link_data_in(link_data_in),
    .link_done(link_done), .link_data_out(link_data_out)
  );

  // Reference rules: rotating priority starting after the last winner.
  function automatic int rr_pick(input int lst, input logic [N-1:0] r);
    for (int i = 1; i <= N; i++) if (r[(lst + i) % N]) return (lst + i) % N;
    return -1;
  endfunction

  // link_done raised d cycles after the launch cycle is seen by the bench
  // reaches done_evt in WAIT cycle d+1; WAIT cycle TO-1 is the last one.
  // Response lands two cycles after that WAIT cycle (d<0 means never).
  function automatic int exp_lat(input int d);
    return (d >= 0 && d <= TO - 2) ? d + 3 : TO + 1;
  endfunction

  function automatic logic exp_to(input int d);
    return !(d >= 0 && d <= TO - 2);
  endfunction

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] v;
    v = '0;
    if (w >= 0) v[w] = 1'b1;
    return v;
  endfunction

  task automatic fill_payloads();
    for (int i = 0; i < N; i++) req_data[i*64 +: 64] = {$urandom, $urandom};
  endtask

  // Stimulus driver for one link transaction; observations only, no checks.
  task automatic run_txn(input int d, input logic [63:0] rword,
                         output int wl, output logic [N-1:0] g, output logic [63:0] lin,
                         output int lat, output logic [N-1:0] rv, output logic rto,
                         output logic [63:0] rd, output logic [N-1:0] grsp);
    wl = 0;
    link_data_out = rword;
    while (!link_out_en && wl < 50) begin
      @(negedge clk);
      wl++;
    end
    g   = gnt;
    lin = link_data_in;
    if (d == 0) link_done = 1'b1;
    lat = 0; rv = '0; rto = 1'b0; rd = '0; grsp = '0;
    while (lat < 60) begin
      @(negedge clk);
      lat++;
      if (|rsp_valid) begin
        rv = rsp_valid; rto = rsp_timeout; rd = rsp_data; grsp = gnt;
        break;
      end
      if (lat == d) link_done = 1'b1;
    end
    link_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; req_data = '0; link_done = 1'b0; link_data_out = '0;
    repeat (3) @(negedge clk);
    total++; if ({gnt, rsp_valid, rsp_timeout, busy, link_out_en} !== '0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0", {gnt, rsp_valid, rsp_timeout, busy, link_out_en});
    end
    total++; if ({rsp_data, link_data_in} !== '0) begin
      bad++; $display("FAIL reset_data: got %h want 0", {rsp_data, link_data_in});
    end
    rst = 1'b0;
    last_m = N - 1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    int wl, lat, w, d; logic [N-1:0] g, rv, grsp; logic rto; logic [63:0] lin, rd, rw, ed;
    req = '1;
    for (int t = 0; t < 8; t++) begin
      fill_payloads();
      d  = $urandom_range(0, 12);
      rw = {$urandom, $urandom};
      w  = rr_pick(last_m, req);
      ed = req_data[w*64 +: 64];
      run_txn(d, rw, wl, g, lin, lat, rv, rto, rd, grsp);
      total++; if (wl !== ((t == 0) ? 1 : 2)) begin bad++; $display("FAIL rr_launch_gap: got %0d want %0d", wl, (t == 0) ? 1 : 2); end
      total++; if (g !== onehot(w) || !$onehot(g)) begin bad++; $display("FAIL rr_gnt: got %b want %b", g, onehot(w)); end
      total++; if (lin !== ed) begin bad++; $display("FAIL rr_payload: got %h want %h", lin, ed); end
      total++; if (lat !== exp_lat(d)) begin bad++; $display("FAIL rr_latency: got %0d want %0d", lat, exp_lat(d)); end
      total++; if (rv !== onehot(w) || grsp !== onehot(w)) begin bad++; $display("FAIL rr_rsp_valid: got %b/%b want %b", rv, grsp, onehot(w)); end
      total++; if (rto !== 1'b0 || rd !== rw) begin bad++; $display("FAIL rr_rsp_data: got %b %h want 0 %h", rto, rd, rw); end
      last_m = w;
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int wl, lat; logic [N-1:0] g, rv, grsp; logic rto; logic [63:0] lin, rd;
    req_data[63:0] = 64'hDEAD_BEEF_CAFE_F00D;
    req = 4'b0001;
    run_txn(10, 64'h1234, wl, g, lin, lat, rv, rto, rd, grsp);
    total++; if (wl !== 1 || g !== 4'b0001) begin bad++; $display("FAIL single_launch: got %0d %b want 1 0001", wl, g); end
    total++; if (lin !== 64'hDEAD_BEEF_CAFE_F00D) begin bad++; $display("FAIL single_payload: got %h want deadbeefcafef00d", lin); end
    total++; if (lat !== 13 || rv !== 4'b0001) begin bad++; $display("FAIL single_rsp: got %0d %b want 13 0001", lat, rv); end
    total++; if (rd !== 64'h1234 || rto !== 1'b0) begin bad++; $display("FAIL single_data: got %h %b want 1234 0", rd, rto); end
    last_m = 0;
    req = '0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || gnt !== '0) begin bad++; $display("FAIL single_idle: got %b %b want 0 0", busy, gnt); end
  endtask

  task automatic test_timeout();
    int wl, lat, w; logic [N-1:0] g, rv, grsp; logic rto; logic [63:0] lin, rd;
    req = 4'b0011;
    w = rr_pick(last_m, req);
    run_txn(-1, 64'hFFFF_0000_1111_2222, wl, g, lin, lat, rv, rto, rd, grsp);
    total++; if (lat !== TO + 1 || rv !== onehot(w)) begin bad++; $display("FAIL to_rsp: got %0d %b want %0d %b", lat, rv, TO + 1, onehot(w)); end
    total++; if (rto !== 1'b1 || rd !== '0) begin bad++; $display("FAIL to_flag: got %b %h want 1 0", rto, rd); end
    last_m = w;
    w = rr_pick(last_m, req);
    run_txn(3, 64'h55, wl, g, lin, lat, rv, rto, rd, grsp);
    total++; if (wl !== 2 || g !== onehot(w)) begin bad++; $display("FAIL to_next_gnt: got %0d %b want 2 %b", wl, g, onehot(w)); end
    total++; if (rto !== 1'b0 || rd !== 64'h55 || lat !== 6) begin bad++; $display("FAIL to_next_rsp: got %b %h %0d want 0 55 6", rto, rd, lat); end
    last_m = w;
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_collision();
    int wl, lat, w; logic [N-1:0] g, rv, grsp; logic rto; logic [63:0] lin, rd, rw;
    req = 4'b1000;
    for (int k = 0; k < 2; k++) begin
      rw = {$urandom, $urandom} | 64'h1;
      w = rr_pick(last_m, req);
      run_txn(TO - 2 + k, rw, wl, g, lin, lat, rv, rto, rd, grsp);
      total++; if (lat !== TO + 1 || rv !== onehot(w)) begin bad++; $display("FAIL coll_rsp%0d: got %0d %b want %0d %b", k, lat, rv, TO + 1, onehot(w)); end
      total++; if (rto !== exp_to(TO - 2 + k) || rd !== (k == 0 ? rw : 64'h0)) begin
        bad++; $display("FAIL coll_data%0d: got %b %h want %b %h", k, rto, rd, exp_to(TO - 2 + k), (k == 0 ? rw : 64'h0));
      end
      last_m = w;
    end
    req = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_req_drop();
    int wl, lat; logic [N-1:0] g, rv, grsp; logic rto; logic [63:0] lin, rd;
    req = 4'b0100;
    @(negedge clk);
    req = '0;
    run_txn(5, 64'hABCD, wl, g, lin, lat, rv, rto, rd, grsp);
    total++; if (wl !== 0 || g !== 4'b0100) begin bad++; $display("FAIL drop_launch: got %0d %b want 0 0100", wl, g); end
    total++; if (rv !== 4'b0100 || rd !== 64'hABCD || lat !== 8) begin bad++; $display("FAIL drop_rsp: got %b %h %0d want 0100 abcd 8", rv, rd, lat); end
    last_m = 2;
    @(negedge clk);
  endtask

  task automatic test_random();
    int wl, lat, w, d; logic [N-1:0] g, rv, grsp; logic rto; logic [63:0] lin, rd, rw, ed;
    for (int t = 0; t < 16; t++) begin
      req = N'($urandom_range(1, (1 << N) - 1));
      fill_payloads();
      d = $urandom_range(0, 17);
      if (d == 17) d = -1;
      rw = {$urandom, $urandom};
      w  = rr_pick(last_m, req);
      ed = req_data[w*64 +: 64];
      run_txn(d, rw, wl, g, lin, lat, rv, rto, rd, grsp);
      total++; if (wl !== ((t == 0) ? 1 : 2) || g !== onehot(w)) begin
        bad++; $display("FAIL rnd_gnt: got %0d %b want %0d %b", wl, g, (t == 0) ? 1 : 2, onehot(w));
      end
      total++; if (lin !== ed) begin bad++; $display("FAIL rnd_payload: got %h want %h", lin, ed); end
      total++; if (lat !== exp_lat(d) || rv !== onehot(w)) begin bad++; $display("FAIL rnd_rsp: got %0d %b want %0d %b (d=%0d)", lat, rv, exp_lat(d), onehot(w), d); end
      total++; if (rto !== exp_to(d) || rd !== (exp_to(d) ? 64'h0 : rw)) begin
        bad++; $display("FAIL rnd_data: got %b %h want %b %h (d=%0d)", rto, rd, exp_to(d), exp_to(d) ? 64'h0 : rw, d);
      end
      last_m = w;
    end
    req = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    int wl, lat; logic [N-1:0] g, rv, grsp; logic rto; logic [63:0] lin, rd;
    req_data[63:0] = 64'h0123_4567_89AB_CDEF;
    req = 4'b0001;
    @(negedge clk);
    req = '0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rmw_busy: got %b want 1", busy); end
    rst = 1'b1;
    #1;
    total++; if ({gnt, rsp_valid, rsp_timeout, busy, link_out_en} !== '0) begin
      bad++; $display("FAIL rmw_ctrl: got %b want 0", {gnt, rsp_valid, rsp_timeout, busy, link_out_en});
    end
    total++; if ({rsp_data, link_data_in} !== '0) begin
      bad++; $display("FAIL rmw_data: got %h want 0", {rsp_data, link_data_in});
    end
    @(negedge clk);
    rst = 1'b0;
    last_m = N - 1;
    req = 4'b0100;
    run_txn(2, 64'h77, wl, g, lin, lat, rv, rto, rd, grsp);
    total++; if (wl !== 1 || g !== 4'b0100) begin bad++; $display("FAIL rmw_regrant: got %0d %b want 1 0100", wl, g); end
    total++; if (rv !== 4'b0100 || rd !== 64'h77) begin bad++; $display("FAIL rmw_rsp: got %b %h want 0100 77", rv, rd); end
    req = '0;
    @(negedge clk);
    link_done = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++; if (rsp_valid !== '0 || busy !== 1'b0) begin bad++; $display("FAIL stale_done: got %b %b want 0 0", rsp_valid, busy); end
    end
    link_done = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_timeout();
    test_collision();
    test_req_drop();
    test_random();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
